// File: rtl/axi_host_bridge_if.sv
// Host-link and pasc memory-port signals of axi_host_bridge.
// The master modport is the bridge itself; the slave modport is the
// environment (host front end plus pasc memory port).
interface axi_host_bridge_if;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        axi_we;
  logic [15:0] axi_addr;
  logic [15:0] axi_data;
  logic [15:0] axi_q;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready, axi_q,
    output cmd_ready, rsp_valid, rsp_data, axi_we, axi_addr, axi_data
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready, axi_q,
    input  cmd_ready, rsp_valid, rsp_data, axi_we, axi_addr, axi_data
  );
endinterface

// File: rtl/axi_host_bridge.sv
// Host-side initiator for the pasc memory port. Decodes a byte-serial
// command stream (single write, auto-incrementing burst write, single read)
// and returns read data to the host as two bytes, high byte first.
// Every output is a register; output flags are derived from the next state.
module axi_host_bridge #(
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  axi_host_bridge_if.master   bus,
  output logic                busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, COUNT, DATA_HI, DATA_LO, WRITE, READ_WAIT, RSP_HI, RSP_LO
  } state_t;

  // Encoding matches the low two opcode bits, so a legal opcode casts directly.
  typedef enum logic [1:0] {OP_NONE, OP_WRITE, OP_READ, OP_BURST} op_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  state_t     state, state_next;
  op_t        op;
  logic [7:0] addr_hi;
  logic [7:0] data_hi;
  logic [7:0] rdata_lo;
  logic [8:0] words;
  logic [1:0] lat_cnt;
  logic       accept;

  assign accept = bus.cmd_valid & bus.cmd_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode from accepted bytes, write progress and read latency.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:      if (accept && (bus.cmd_data inside {8'h01, 8'h02, 8'h03}))
                   state_next = ADDR_HI;
      ADDR_HI:   if (accept) state_next = ADDR_LO;
      ADDR_LO:   if (accept) begin
                   case (op)
                     OP_BURST: state_next = COUNT;
                     OP_READ:  state_next = READ_WAIT;
                     default:  state_next = DATA_HI;
                   endcase
                 end
      COUNT:     if (accept) state_next = DATA_HI;
      DATA_HI:   if (accept) state_next = DATA_LO;
      DATA_LO:   if (accept) state_next = WRITE;
      WRITE:     state_next = (words == 9'd1) ? IDLE : DATA_HI;
      READ_WAIT: if (lat_cnt == LAT_LAST) state_next = RSP_HI;
      RSP_HI:    if (bus.rsp_ready) state_next = RSP_LO;
      RSP_LO:    if (bus.rsp_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Registered outputs and datapath: field capture, word counting,
  // address increment and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.axi_we    <= 1'b0;
      bus.axi_addr  <= '0;
      bus.axi_data  <= '0;
      busy          <= 1'b0;
      op            <= OP_NONE;
      addr_hi       <= '0;
      data_hi       <= '0;
      rdata_lo      <= '0;
      words         <= '0;
      lat_cnt       <= '0;
    end else begin
      bus.cmd_ready <= state_next inside {IDLE, ADDR_HI, ADDR_LO, COUNT, DATA_HI, DATA_LO};
      bus.rsp_valid <= state_next inside {RSP_HI, RSP_LO};
      bus.axi_we    <= (state_next == WRITE);
      busy          <= (state_next != IDLE);

      unique case (state)
        IDLE:      if (accept) op <= op_t'(bus.cmd_data[1:0]);
        ADDR_HI:   if (accept) addr_hi <= bus.cmd_data;
        ADDR_LO:   if (accept) begin
                     bus.axi_addr <= {addr_hi, bus.cmd_data};
                     words        <= 9'd1;
                     lat_cnt      <= '0;
                   end
        // A count byte of zero means a full 256-word burst.
        COUNT:     if (accept) words <= (bus.cmd_data == 8'h00) ? 9'd256 : {1'b0, bus.cmd_data};
        DATA_HI:   if (accept) data_hi <= bus.cmd_data;
        DATA_LO:   if (accept) bus.axi_data <= {data_hi, bus.cmd_data};
        // The address only advances when another word follows, so an idle
        // bridge keeps showing the last address it wrote.
        WRITE:     begin
                     words <= words - 9'd1;
                     if (words != 9'd1) bus.axi_addr <= bus.axi_addr + 16'd1;
                   end
        READ_WAIT: begin
                     lat_cnt <= lat_cnt + 2'd1;
                     if (lat_cnt == LAT_LAST) begin
                       bus.rsp_data <= bus.axi_q[15:8];
                       rdata_lo     <= bus.axi_q[7:0];
                     end
                   end
        RSP_HI:    if (bus.rsp_ready) bus.rsp_data <= rdata_lo;
        default:   ;
      endcase
    end
  end

endmodule
